// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: instruction fetch port, data port and the
// shared downstream memory port. The slave modport is the arbiter's view.
interface mem_arbiter_if #(
  parameter int unsigned AW = 16
);
  logic [15:0]   i_addr;
  logic          i_oe;
  logic [31:0]   i_rdata;
  logic          i_ready;
  logic [31:0]   d_addr;
  logic          d_oe;
  logic [3:0]    d_we;
  logic [31:0]   d_wdata;
  logic [31:0]   d_rdata;
  logic          d_ready;
  logic          m_valid;
  logic          m_ready;
  logic [AW-1:0] m_addr;
  logic [3:0]    m_we;
  logic [31:0]   m_wdata;
  logic          m_rvalid;
  logic [31:0]   m_rdata;

  modport slave (
    input  i_addr, i_oe, d_addr, d_oe, d_we, d_wdata, m_ready, m_rvalid, m_rdata,
    output i_rdata, i_ready, d_rdata, d_ready, m_valid, m_addr, m_we, m_wdata
  );

  modport master (
    output i_addr, i_oe, d_addr, d_oe, d_we, d_wdata, m_ready, m_rvalid, m_rdata,
    input  i_rdata, i_ready, d_rdata, d_ready, m_valid, m_addr, m_we, m_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// I/D arbiter onto one single-port memory with a posted write buffer.
// Define MEM_ARB_RR_EN for round-robin between I-reads and the D side.
module mem_arbiter #(
  parameter int unsigned AW         = 16,
  parameter int unsigned WBUF_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);
  localparam int unsigned PW = $clog2(WBUF_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(WBUF_DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] IRD  = 2'd1;
  localparam logic [1:0] DRD  = 2'd2;
  localparam logic [1:0] WR   = 2'd3;

  logic [1:0]    state;
  logic          i_pend, d_pend;
  logic [AW-1:0] i_addr_q, d_addr_q;
  logic [3:0]    d_we_q;
  logic [31:0]   d_wdata_q;
  logic          m_valid_q;
  logic [AW-1:0] m_addr_q;
  logic [3:0]    m_we_q;
  logic [31:0]   m_wdata_q, i_rdata_q, d_rdata_q;

  logic [AW-1:0] wb_addr [WBUF_DEPTH];
  logic [3:0]    wb_we   [WBUF_DEPTH];
  logic [31:0]   wb_data [WBUF_DEPTH];
  logic [PW-1:0] wb_rd, wb_wr;
  logic [PW:0]   wb_cnt;

`ifdef MEM_ARB_RR_EN
  logic          rr_i_next;
`endif

  logic          wb_empty, wb_full, i_acc, d_acc, d_st_now, d_ld_now, st_pend, ld_pend;
  logic          push, pop, rd_done, i_want, cand_drd, cand_wr, pick_i;
  logic          gnt_i, gnt_drd, gnt_wr;
  logic [AW-1:0] push_addr, i_cur_addr, d_cur_addr;
  logic [3:0]    push_we;
  logic [31:0]   push_data;

  // Upper address bits are dropped on purpose; this sink keeps them accounted for.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.d_addr, bus.i_addr};

  always_comb begin
    wb_empty   = (wb_cnt == '0);
    wb_full    = (wb_cnt == FULL_CNT);
    i_acc      = bus.i_oe && !i_pend;
    d_acc      = bus.d_oe && !d_pend;
    d_st_now   = d_acc && (bus.d_we != 4'b0000);
    d_ld_now   = d_acc && (bus.d_we == 4'b0000);
    st_pend    = d_pend && (d_we_q != 4'b0000);
    ld_pend    = d_pend && (d_we_q == 4'b0000);
    push       = (d_st_now || st_pend) && !wb_full;
    push_addr  = st_pend ? d_addr_q  : AW'(bus.d_addr);
    push_we    = st_pend ? d_we_q    : bus.d_we;
    push_data  = st_pend ? d_wdata_q : bus.d_wdata;
    pop        = (state == WR) && m_valid_q && bus.m_ready;
    rd_done    = !m_valid_q && bus.m_rvalid;
    // Requests arriving this cycle compete too, so a load can issue next cycle.
    i_want     = i_pend || i_acc;
    i_cur_addr = i_pend ? i_addr_q : AW'(bus.i_addr);
    d_cur_addr = d_pend ? d_addr_q : AW'(bus.d_addr);
    cand_drd   = (ld_pend || d_ld_now) && wb_empty;
    cand_wr    = !wb_empty;
`ifdef MEM_ARB_RR_EN
    pick_i     = i_want && (rr_i_next || !(cand_drd || cand_wr));
`else
    pick_i     = i_want && !(cand_drd || cand_wr);
`endif
    gnt_i      = (state == IDLE) && pick_i;
    gnt_drd    = (state == IDLE) && !pick_i && cand_drd;
    gnt_wr     = (state == IDLE) && !pick_i && cand_wr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_rd  <= '0;
      wb_wr  <= '0;
      wb_cnt <= '0;
      for (int unsigned k = 0; k < WBUF_DEPTH; k++) begin
        wb_addr[PW'(k)] <= '0;
        wb_we[PW'(k)]   <= '0;
        wb_data[PW'(k)] <= '0;
      end
    end else begin
      if (push) begin
        wb_addr[wb_wr] <= push_addr;
        wb_we[wb_wr]   <= push_we;
        wb_data[wb_wr] <= push_data;
        wb_wr          <= wb_wr + 1'b1;
      end
      if (pop) wb_rd <= wb_rd + 1'b1;
      if (push && !pop)      wb_cnt <= wb_cnt + 1'b1;
      else if (!push && pop) wb_cnt <= wb_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      i_pend    <= 1'b0;
      d_pend    <= 1'b0;
      i_addr_q  <= '0;
      d_addr_q  <= '0;
      d_we_q    <= '0;
      d_wdata_q <= '0;
      m_valid_q <= 1'b0;
      m_addr_q  <= '0;
      m_we_q    <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (i_acc) begin
        i_pend   <= 1'b1;
        i_addr_q <= AW'(bus.i_addr);
      end
      if (state == IRD && rd_done) begin
        i_pend    <= 1'b0;
        i_rdata_q <= bus.m_rdata;
      end

      if (d_acc) begin
        d_addr_q  <= AW'(bus.d_addr);
        d_we_q    <= bus.d_we;
        d_wdata_q <= bus.d_wdata;
      end
      if (d_ld_now || (d_st_now && wb_full)) d_pend <= 1'b1;
      else if (st_pend && !wb_full)           d_pend <= 1'b0;
      else if (state == DRD && rd_done)       d_pend <= 1'b0;
      if (state == DRD && rd_done) d_rdata_q <= bus.m_rdata;

      case (state)
        IDLE: begin
          if (gnt_drd) begin
            state     <= DRD;
            m_valid_q <= 1'b1;
            m_addr_q  <= d_cur_addr;
            m_we_q    <= 4'b0000;
            m_wdata_q <= '0;
          end else if (gnt_wr) begin
            state     <= WR;
            m_valid_q <= 1'b1;
            m_addr_q  <= wb_addr[wb_rd];
            m_we_q    <= wb_we[wb_rd];
            m_wdata_q <= wb_data[wb_rd];
          end else if (gnt_i) begin
            state     <= IRD;
            m_valid_q <= 1'b1;
            m_addr_q  <= i_cur_addr;
            m_we_q    <= 4'b0000;
            m_wdata_q <= '0;
          end
        end
        WR: begin
          if (bus.m_ready) begin
            m_valid_q <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          if (m_valid_q) begin
            if (bus.m_ready) m_valid_q <= 1'b0;
          end else if (bus.m_rvalid) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  rr_i_next <= 1'b0;
    else if (gnt_i)              rr_i_next <= 1'b0;
    else if (gnt_drd || gnt_wr)  rr_i_next <= 1'b1;
  end
`endif

  assign bus.i_ready = !i_pend;
  assign bus.d_ready = !d_pend;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.m_valid = m_valid_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_we    = m_we_q;
  assign bus.m_wdata = m_wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a 1-cycle memory model
// that logs every downstream handshake.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  mem_arbiter_if #(.AW(16)) bus ();
  mem_arbiter #(.AW(16), .WBUF_DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct { logic [15:0] addr; logic [3:0] we; logic [31:0] data; } txn_t;
  txn_t        log_q[$];
  logic [1023:0] wr_valid = '0;
  logic [31:0] wr_word [1024];
  logic        rv_model = 1'b0;
  logic [31:0] rd_model = '0;
  logic        rv_inject;
  logic [31:0] inj_data;

  // Unwritten words read back as {~addr, addr}, except 0x0010 which holds 0x13.
  function automatic logic [31:0] mem_init(input logic [15:0] a);
    return (a == 16'h0010) ? 32'h0000_0013 : {~a, a};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    rv_model <= 1'b0;
    if (rst_n && bus.m_valid && bus.m_ready) begin
      log_q.push_back('{bus.m_addr, bus.m_we, bus.m_wdata});
      if (bus.m_we == 4'b0000) begin
        rv_model <= 1'b1;
        rd_model <= wr_valid[bus.m_addr[11:2]] ? wr_word[bus.m_addr[11:2]] : mem_init(bus.m_addr);
      end else begin
        wr_word[bus.m_addr[11:2]]  <= merge(wr_valid[bus.m_addr[11:2]] ? wr_word[bus.m_addr[11:2]]
                                            : mem_init(bus.m_addr), bus.m_wdata, bus.m_we);
        wr_valid[bus.m_addr[11:2]] <= 1'b1;
      end
    end
  end

  assign bus.m_rvalid = rv_model | rv_inject;
  assign bus.m_rdata  = rv_inject ? inj_data : rd_model;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    checks++; if (bus.i_ready !== 1'b1) begin failures++; $display("FAIL reset_i_ready got=%h exp=1", bus.i_ready); end
    checks++; if (bus.d_ready !== 1'b1) begin failures++; $display("FAIL reset_d_ready got=%h exp=1", bus.d_ready); end
    checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%h exp=0", bus.m_valid); end
    checks++; if (bus.m_we !== 4'h0) begin failures++; $display("FAIL reset_m_we got=%h exp=0", bus.m_we); end
    checks++; if (bus.m_addr !== 16'h0) begin failures++; $display("FAIL reset_m_addr got=%h exp=0", bus.m_addr); end
    checks++; if (bus.m_wdata !== 32'h0) begin failures++; $display("FAIL reset_m_wdata got=%h exp=0", bus.m_wdata); end
    checks++; if (bus.i_rdata !== 32'h0) begin failures++; $display("FAIL reset_i_rdata got=%h exp=0", bus.i_rdata); end
    checks++; if (bus.d_rdata !== 32'h0) begin failures++; $display("FAIL reset_d_rdata got=%h exp=0", bus.d_rdata); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_fetch();
    bus.m_ready = 1'b1;
    bus.i_addr  = 16'h0010;
    bus.i_oe    = 1'b1;
    tick();
    bus.i_oe = 1'b0;
    checks++; if (bus.i_ready !== 1'b0) begin failures++; $display("FAIL fetch_ready_t1 got=%h exp=0", bus.i_ready); end
    checks++; if (bus.m_valid !== 1'b1) begin failures++; $display("FAIL fetch_m_valid_t1 got=%h exp=1", bus.m_valid); end
    checks++; if (bus.m_addr !== 16'h0010) begin failures++; $display("FAIL fetch_m_addr got=%h exp=0010", bus.m_addr); end
    checks++; if (bus.m_we !== 4'h0) begin failures++; $display("FAIL fetch_m_we got=%h exp=0", bus.m_we); end
    tick();
    checks++; if (bus.i_ready !== 1'b0) begin failures++; $display("FAIL fetch_ready_t2 got=%h exp=0", bus.i_ready); end
    tick();
    checks++; if (bus.i_ready !== 1'b1) begin failures++; $display("FAIL fetch_ready_t3 got=%h exp=1", bus.i_ready); end
    checks++; if (bus.i_rdata !== 32'h0000_0013) begin failures++; $display("FAIL fetch_rdata got=%h exp=00000013", bus.i_rdata); end
  endtask

  task automatic test_store_then_load();
    int base = log_q.size();
    bus.d_addr  = 32'h0000_0100;
    bus.d_we    = 4'b1111;
    bus.d_wdata = 32'hDEAD_BEEF;
    bus.d_oe    = 1'b1;
    checks++; if (bus.d_ready !== 1'b1) begin failures++; $display("FAIL store_accept_ready got=%h exp=1", bus.d_ready); end
    tick();
    checks++; if (bus.d_ready !== 1'b1) begin failures++; $display("FAIL store_posted_ready got=%h exp=1", bus.d_ready); end
    bus.d_we = 4'b0000;
    tick();
    bus.d_oe = 1'b0;
    checks++; if (bus.d_ready !== 1'b0) begin failures++; $display("FAIL load_pending_ready got=%h exp=0", bus.d_ready); end
    for (int k = 0; k < 30 && bus.d_ready !== 1'b1; k++) tick();
    checks++; if (bus.d_ready !== 1'b1) begin failures++; $display("FAIL load_timeout got=%h exp=1", bus.d_ready); end
    checks++; if (bus.d_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL load_rdata got=%h exp=deadbeef", bus.d_rdata); end
    checks++; if (log_q.size() - base !== 2) begin failures++; $display("FAIL sl_txn_count got=%0d exp=2", log_q.size() - base); end
    if (log_q.size() >= base + 2) begin
      checks++; if (log_q[base].we !== 4'b1111) begin failures++; $display("FAIL sl_first_is_write got=%h exp=f", log_q[base].we); end
      checks++; if (log_q[base].data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL sl_write_data got=%h exp=deadbeef", log_q[base].data); end
      checks++; if (log_q[base+1].we !== 4'b0000) begin failures++; $display("FAIL sl_second_is_read got=%h exp=0", log_q[base+1].we); end
      checks++; if (log_q[base+1].addr !== 16'h0100) begin failures++; $display("FAIL sl_read_addr got=%h exp=0100", log_q[base+1].addr); end
    end
  endtask

  task automatic test_buffer_full();
    int base = log_q.size();
    bus.m_ready = 1'b0;
    bus.d_we    = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      bus.d_addr  = 32'h0000_0300 + 32'(4 * k);
      bus.d_wdata = 32'h1000_0000 + 32'(k);
      bus.d_oe    = 1'b1;
      checks++; if (bus.d_ready !== 1'b1) begin failures++; $display("FAIL full_store%0d_ready got=%h exp=1", k, bus.d_ready); end
      tick();
    end
    bus.d_oe = 1'b0;
    checks++; if (bus.d_ready !== 1'b0) begin failures++; $display("FAIL full_fifth_stalled got=%h exp=0", bus.d_ready); end
    tick();
    checks++; if (bus.d_ready !== 1'b0) begin failures++; $display("FAIL full_still_stalled got=%h exp=0", bus.d_ready); end
    checks++; if (bus.m_valid !== 1'b1) begin failures++; $display("FAIL full_wr_held_valid got=%h exp=1", bus.m_valid); end
    checks++; if (bus.m_addr !== 16'h0300) begin failures++; $display("FAIL full_wr_held_addr got=%h exp=0300", bus.m_addr); end
    bus.m_ready = 1'b1;
    tick();
    checks++; if (bus.d_ready !== 1'b0) begin failures++; $display("FAIL full_drain_edge got=%h exp=0", bus.d_ready); end
    tick();
    checks++; if (bus.d_ready !== 1'b1) begin failures++; $display("FAIL full_slot_freed got=%h exp=1", bus.d_ready); end
    for (int k = 0; k < 60 && log_q.size() < base + 5; k++) tick();
    checks++; if (log_q.size() - base !== 5) begin failures++; $display("FAIL full_txn_count got=%0d exp=5", log_q.size() - base); end
    for (int k = 0; k < 5 && log_q.size() >= base + 5; k++) begin
      checks++; if (log_q[base+k].addr !== 16'h0300 + 16'(4 * k)) begin failures++; $display("FAIL full_order_addr%0d got=%h exp=%h", k, log_q[base+k].addr, 16'h0300 + 16'(4 * k)); end
      checks++; if (log_q[base+k].data !== 32'h1000_0000 + 32'(k)) begin failures++; $display("FAIL full_order_data%0d got=%h exp=%h", k, log_q[base+k].data, 32'h1000_0000 + 32'(k)); end
    end
    repeat (3) tick();
  endtask

  task automatic test_simultaneous();
    bus.m_ready = 1'b1;
    bus.i_addr  = 16'h0020;
    bus.i_oe    = 1'b1;
    bus.d_addr  = 32'h0000_0200;
    bus.d_we    = 4'b0000;
    bus.d_oe    = 1'b1;
    tick();
    bus.i_oe = 1'b0;
    bus.d_oe = 1'b0;
    checks++; if (bus.m_addr !== 16'h0200) begin failures++; $display("FAIL simul_d_first got=%h exp=0200", bus.m_addr); end
    checks++; if (bus.i_ready !== 1'b0) begin failures++; $display("FAIL simul_i_captured got=%h exp=0", bus.i_ready); end
    checks++; if (bus.d_ready !== 1'b0) begin failures++; $display("FAIL simul_d_captured got=%h exp=0", bus.d_ready); end
    repeat (2) tick();
    checks++; if (bus.d_ready !== 1'b1) begin failures++; $display("FAIL simul_d_done got=%h exp=1", bus.d_ready); end
    checks++; if (bus.d_rdata !== 32'hFDFF_0200) begin failures++; $display("FAIL simul_d_rdata got=%h exp=fdff0200", bus.d_rdata); end
    checks++; if (bus.i_ready !== 1'b0) begin failures++; $display("FAIL simul_i_waits got=%h exp=0", bus.i_ready); end
    tick();
    checks++; if (bus.m_addr !== 16'h0020) begin failures++; $display("FAIL simul_i_issued got=%h exp=0020", bus.m_addr); end
    for (int k = 0; k < 20 && bus.i_ready !== 1'b1; k++) tick();
    checks++; if (bus.i_ready !== 1'b1) begin failures++; $display("FAIL simul_i_timeout got=%h exp=1", bus.i_ready); end
    checks++; if (bus.i_rdata !== 32'hFFDF_0020) begin failures++; $display("FAIL simul_i_rdata got=%h exp=ffdf0020", bus.i_rdata); end
  endtask

  task automatic test_fetch_vs_stores();
    int base = log_q.size();
    int rd_idx = -1;
    int exp_idx;
`ifdef MEM_ARB_RR_EN
    exp_idx = 1;
`else
    exp_idx = 3;
`endif
    bus.m_ready = 1'b0;
    bus.d_we    = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      bus.d_addr  = 32'h0000_0600 + 32'(4 * k);
      bus.d_wdata = 32'hC000_0000 + 32'(k);
      bus.d_oe    = 1'b1;
      tick();
    end
    bus.d_oe   = 1'b0;
    bus.i_addr = 16'h0040;
    bus.i_oe   = 1'b1;
    tick();
    bus.i_oe    = 1'b0;
    bus.m_ready = 1'b1;
    for (int k = 0; k < 80 && (bus.i_ready !== 1'b1 || log_q.size() < base + 4); k++) tick();
    checks++; if (log_q.size() - base !== 4) begin failures++; $display("FAIL fair_txn_count got=%0d exp=4", log_q.size() - base); end
    for (int k = 0; k < log_q.size() - base; k++) if (log_q[base+k].we == 4'b0000 && rd_idx < 0) rd_idx = k;
    checks++; if (rd_idx !== exp_idx) begin failures++; $display("FAIL fair_fetch_slot got=%0d exp=%0d", rd_idx, exp_idx); end
    checks++; if (bus.i_rdata !== 32'hFFBF_0040) begin failures++; $display("FAIL fair_i_rdata got=%h exp=ffbf0040", bus.i_rdata); end
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    bus.m_ready = 1'b0;
    bus.d_addr  = 32'h0000_0500;
    bus.d_we    = 4'b0000;
    bus.d_oe    = 1'b1;
    tick();
    bus.d_oe = 1'b0;
    checks++; if (bus.m_valid !== 1'b1) begin failures++; $display("FAIL mid_in_drd got=%h exp=1", bus.m_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_m_valid got=%h exp=0", bus.m_valid); end
    checks++; if (bus.m_addr !== 16'h0) begin failures++; $display("FAIL mid_rst_m_addr got=%h exp=0", bus.m_addr); end
    checks++; if (bus.d_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_d_ready got=%h exp=1", bus.d_ready); end
    checks++; if (bus.i_rdata !== 32'h0) begin failures++; $display("FAIL mid_rst_i_rdata got=%h exp=0", bus.i_rdata); end
    checks++; if (bus.d_rdata !== 32'h0) begin failures++; $display("FAIL mid_rst_d_rdata got=%h exp=0", bus.d_rdata); end
    tick();
    rst_n = 1'b1;
    tick();
    inj_data  = 32'hBAD0_BAD0;
    rv_inject = 1'b1;
    tick();
    rv_inject = 1'b0;
    tick();
    checks++; if (bus.d_rdata !== 32'h0) begin failures++; $display("FAIL stale_rvalid_d_rdata got=%h exp=0", bus.d_rdata); end
    checks++; if (bus.d_ready !== 1'b1) begin failures++; $display("FAIL stale_rvalid_d_ready got=%h exp=1", bus.d_ready); end
    checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL stale_rvalid_m_valid got=%h exp=0", bus.m_valid); end
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.i_addr  = '0;
    bus.i_oe    = 1'b0;
    bus.d_addr  = '0;
    bus.d_oe    = 1'b0;
    bus.d_we    = '0;
    bus.d_wdata = '0;
    bus.m_ready = 1'b0;
    rv_inject   = 1'b0;
    inj_data    = '0;
    test_reset();
    test_single_fetch();
    test_store_then_load();
    test_buffer_full();
    test_simultaneous();
    test_fetch_vs_stores();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout time=%0t limit=200000", $time);
    $fatal(1);
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port downstream memory between the processor's instruction fetch port (I) and data port (D).
- Stores are posted through a small write buffer, so a store never waits on the downstream memory unless the buffer is full.
- D reads are ordered behind all buffered stores. I reads do not check the buffer.
- Only one downstream transaction is in flight at a time.

Parameters:
AW, 16, downstream byte-address width. I and D addresses are truncated to the low AW bits.
WBUF_DEPTH, 4, write buffer entries (power of two, minimum 2).

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
i_addr  in  16  fetch byte address
i_oe  in  1  fetch request
i_rdata  out  32  fetch data
i_ready  out  1  fetch port idle, or response valid this cycle
d_addr  in  32  data byte address
d_oe  in  1  data request (load or store)
d_we  in  4  byte strobes; 0000 means load
d_wdata  in  32  store data
d_rdata  out  32  load data
d_ready  out  1  data port idle, or load response / store acceptance this cycle
m_valid  out  1  downstream request valid
m_ready  in  1  downstream accepts request
m_addr  out  AW  downstream address
m_we  out  4  downstream strobes; 0000 means read
m_wdata  out  32  downstream write data
m_rvalid  in  1  downstream read data valid
m_rdata  in  32  downstream read data

Behaviour:
- Reset (asynchronous, rst_n=0): every register cleared; state IDLE. Outputs: i_ready=1, d_ready=1, m_valid=0, m_we=0, m_addr=0, m_wdata=0, i_rdata=0, d_rdata=0; buffer empty.
- Port capture:
  - A request is accepted only in a cycle where oe=1 and the port's ready=1.
  - oe while ready=0 is ignored; the requester holds its request fields stable until ready=1.
  - A load, or a store arriving with the buffer full, sets that port's pending flag. ready drops to 0 from the next cycle.
  - A store arriving with the buffer not full is written into the buffer in the same edge; d_ready stays 1.
- Write buffer:
  - FIFO of {addr, strobes, data}.
  - Full/empty are decided on the pre-edge count, so a same-cycle drain does not admit a store when the count equals WBUF_DEPTH.
  - A pending store enters the buffer on the first edge with a free slot; d_ready is 1 in the cycle after it enters.
- State machine (IDLE, IRD, DRD, WR):
  - IDLE picks one candidate per cycle:
    - D-read pending and buffer empty.
    - Buffer non-empty (drain head).
    - I-read pending.
  - Default order is D-read, drain, I-read.
  - Ordering rule: a D read never issues while the buffer is non-empty.
  - Moving from IDLE to IRD, DRD or WR drives m_valid=1 from the next cycle.
  - m_valid and m_addr/m_we/m_wdata are held stable until the cycle m_ready=1.
  - WR: on m_ready, pop the head and return to IDLE.
  - IRD / DRD: after m_ready, wait for m_rvalid, then return to IDLE.
- Read response:
  - On m_rvalid, m_rdata is registered into i_rdata or d_rdata.
  - That port's ready=1 in the following cycle and its pending flag clears.
  - i_rdata/d_rdata hold their value until the next response to the same port.
- Minimum read latency: request at cycle t, m_valid at t+1, m_rvalid at t+2 (with a 1-cycle memory), ready=1 with data at t+3.
- Boundary cases:
  - m_rvalid while no read is outstanding: ignored.
  - I and D requests in the same cycle: both captured.
  - Reset mid-transaction: the in-flight transaction is abandoned and buffered stores are discarded. A late m_rvalid after reset is ignored.
- Addresses are passed unaligned; alignment and byte lanes are the memory's job.

Optional Feature:
MEM_ARB_RR_EN
- Defined: round-robin fairness between I-read and the D side (D-read or drain). After a D-side grant, a pending I-read wins the next IDLE decision, and vice versa. The D-read vs drain ordering rule still holds.
- Undefined: fixed priority D-read, drain, I-read. I can starve under continuous D traffic.

Test Plan:
- Single fetch: i_addr=0x0010, i_oe=1 at t, m_ready=1, m_rvalid at t+2 with m_rdata=0x00000013 -> i_ready=0 at t+1 and t+2; i_ready=1 and i_rdata=0x00000013 at t+3.
- Posted store then load, same address: store d_addr=0x100, d_we=1111, d_wdata=0xDEADBEEF, then load 0x100 -> exactly one downstream write (m_we=1111) precedes the read; d_rdata=0xDEADBEEF from the memory model.
- Buffer full: m_ready=0, 5 back-to-back stores with WBUF_DEPTH=4 -> first four keep d_ready=1; fifth gives d_ready=0 until m_ready=1 frees a slot; downstream writes appear in program order.
- Simultaneous I and D loads at t (addresses 0x20, 0x200) -> D read issued first. Without MEM_ARB_RR_EN, I waits for the D response; both ports return correct data.
- Starvation check with MEM_ARB_RR_EN defined: continuous stores plus one pending fetch -> m_valid for the fetch appears no later than the second downstream grant.
- Async reset asserted while in DRD, with m_rvalid arriving one cycle after reset release -> all outputs at reset values; the stale m_rvalid is ignored and d_rdata stays 0.
